// File: rtl/result_collector_pkg.sv
// Shared types and constants for the result collector and its FIFO.
package result_collector_pkg;

    localparam int RESULT_WIDTH = 16;
    localparam int FIFO_DEPTH   = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_SEND,
        S_SEND_LO,
        S_DONE
    } collector_state_e;

    typedef struct packed {
        logic rst_fifo;
        logic push;
    } collector_ctrl_t;

    typedef struct packed {
        logic       done;
        logic       overflow;
        logic [3:0] count;
    } result_collector_status_t;

    // Batch length is N clamped to the FIFO depth.
    function automatic logic [3:0] batch_len(input logic [3:0] n, input int depth);
        return (n > 4'(depth)) ? 4'(depth) : n;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Circular result buffer with wrapping pointers, occupancy count and synchronous clear.
module result_fifo
    import result_collector_pkg::*;
#(
    parameter int WIDTH = RESULT_WIDTH,
    parameter int DEPTH = FIFO_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_wr, do_rd;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_wr   = wr_en && !full && !clr;
    assign do_rd   = rd_en && !empty && !clr;
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/result_collector.sv
// Collects a batch of processor results into a FIFO, drains them over valid/ready, pulses done.
// Optional TX_BYTE_SPLIT_EN sends each result as two bytes, MSB first.
//
// state     | meaning
// S_IDLE    | no batch open; first accepted push latches the batch length
// S_COLLECT | accepting pushes until L results are written
// S_SEND    | presenting head result (MSB byte in byte-split builds)
// S_SEND_LO | presenting LSB byte of head result (byte-split builds only)
// S_DONE    | one-cycle done pulse; batch counters cleared
module result_collector
    import result_collector_pkg::*;
#(
    parameter int DATA_WIDTH = RESULT_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH,
    parameter int PROCESSORS = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             rst_fifo,
    input  logic                             push_result,
    input  logic [1:0]                       processor_number,
    input  logic [PROCESSORS*DATA_WIDTH-1:0] proc_result,
    input  logic [3:0]                       N,
    output logic [DATA_WIDTH-1:0]            tx_data,
    output logic                             tx_valid,
    input  logic                             tx_ready,
    output logic                             done,
    output logic [3:0]                       count,
    output logic                             overflow
);
    collector_state_e         state_q, state_d;
    collector_ctrl_t          ctrl;
    result_collector_status_t status;

    logic [3:0]            written_q, written_d, sent_q, sent_d, len_q, len_d, len_eff, fifo_count;
    logic                  overflow_q, overflow_d;
    logic                  push_ok, pop, hs, proc_ok, fifo_full, fifo_empty;
    logic                  tx_valid_w, done_w;
    logic [DATA_WIDTH-1:0] tx_data_w, sel_data, head;

    assign ctrl     = '{rst_fifo: rst_fifo, push: push_result};
    assign proc_ok  = int'(processor_number) < PROCESSORS;
    assign sel_data = proc_result[int'(processor_number)*DATA_WIDTH +: DATA_WIDTH];
    // In IDLE the length is not latched yet, so judge the push against the live N.
    assign len_eff  = (state_q == S_IDLE) ? batch_len(N, DEPTH) : len_q;
    assign push_ok  = ctrl.push && proc_ok && !fifo_full && (written_q < len_eff)
                      && (state_q == S_IDLE || state_q == S_COLLECT);
    assign hs       = tx_valid_w && tx_ready;
`ifdef TX_BYTE_SPLIT_EN
    assign pop      = hs && !fifo_empty && (state_q == S_SEND_LO);
`else
    assign pop      = hs && !fifo_empty && (state_q == S_SEND);
`endif

    result_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .CNT_W(4)) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .clr    (ctrl.rst_fifo),
        .wr_en  (push_ok),
        .wr_data(sel_data),
        .rd_en  (pop),
        .rd_data(head),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_comb begin
        written_d  = written_q;
        sent_d     = sent_q;
        len_d      = len_q;
        overflow_d = overflow_q;
        if (ctrl.rst_fifo) begin
            written_d  = '0;
            sent_d     = '0;
            len_d      = '0;
            overflow_d = 1'b0;
        end else begin
            if (push_ok) begin
                written_d = written_q + 4'd1;
                if (state_q == S_IDLE) len_d = len_eff;
            end
            if (pop) sent_d = sent_q + 4'd1;
            if (state_q == S_DONE) begin
                written_d = '0;
                sent_d    = '0;
            end
            if (ctrl.push && !push_ok) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            written_q  <= '0;
            sent_q     <= '0;
            len_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            written_q  <= written_d;
            sent_q     <= sent_d;
            len_q      <= len_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (ctrl.rst_fifo) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    if (push_ok) state_d = (written_d == len_eff) ? S_SEND : S_COLLECT;
                S_COLLECT: if (written_d == len_q) state_d = S_SEND;
`ifdef TX_BYTE_SPLIT_EN
                S_SEND:    if (hs) state_d = S_SEND_LO;
                S_SEND_LO: if (pop) state_d = (sent_d == len_q) ? S_DONE : S_SEND;
`else
                S_SEND:    if (pop && sent_d == len_q) state_d = S_DONE;
`endif
                S_DONE:    state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        tx_valid_w = 1'b0;
        done_w     = 1'b0;
        tx_data_w  = '0;
        case (state_q)
            S_SEND: begin
                tx_valid_w = 1'b1;
`ifdef TX_BYTE_SPLIT_EN
                tx_data_w[7:0] = head[DATA_WIDTH-1 -: 8];
`else
                tx_data_w = head;
`endif
            end
`ifdef TX_BYTE_SPLIT_EN
            S_SEND_LO: begin
                tx_valid_w     = 1'b1;
                tx_data_w[7:0] = head[7:0];
            end
`endif
            S_DONE:  done_w = 1'b1;
            default: ;
        endcase
    end

    assign status   = '{done: done_w, overflow: overflow_q, count: fifo_count};
    assign tx_data  = tx_data_w;
    assign tx_valid = tx_valid_w;
    assign done     = status.done;
    assign overflow = status.overflow;
    assign count    = status.count;

endmodule

// File: tb/tb_result_collector.sv
// Bench for result_collector: directed scenarios plus random batches against a queue model.
module tb_result_collector;
    import result_collector_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int P     = 4;

    logic            clk = 1'b0;
    logic            reset, rst_fifo, push_result, tx_ready;
    logic [1:0]      processor_number;
    logic [P*DW-1:0] proc_result;
    logic [3:0]      N;
    logic [DW-1:0]   tx_data;
    logic            tx_valid, done, overflow;
    logic [3:0]      count;

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_q[$];
    bit            exp_ovf = 1'b0;

    always #5 clk = ~clk;

    result_collector #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PROCESSORS(P)) dut (
        .clk             (clk),
        .reset           (reset),
        .rst_fifo        (rst_fifo),
        .push_result     (push_result),
        .processor_number(processor_number),
        .proc_result     (proc_result),
        .N               (N),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .done            (done),
        .count           (count),
        .overflow        (overflow)
    );

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] beat_val(input logic [DW-1:0] r, input int beat);
`ifdef TX_BYTE_SPLIT_EN
        return (beat == 0) ? {8'h00, r[15:8]} : {8'h00, r[7:0]};
`else
        return (beat == 0) ? r : r;
`endif
    endfunction

    task automatic do_push(input int proc, input logic [DW-1:0] val);
        for (int k = 0; k < P; k++) proc_result[k*DW +: DW] = DW'($urandom);
        proc_result[proc*DW +: DW] = val;
        processor_number = 2'(proc);
        push_result = 1'b1;
        tick();
        push_result = 1'b0;
    endtask

    // Push one batch (random or base*(i+1) values), then 'extra' pushes that land in SEND.
    task automatic collect(input int n, input logic [DW-1:0] base, input int extra);
        int len;
        logic [DW-1:0] v;
        len = (n > DEPTH) ? DEPTH : n;
        N = 4'(n);
        tx_ready = 1'($urandom_range(0, 1));
        for (int i = 0; i < len; i++) begin
            if (base == '0) repeat ($urandom_range(0, 2)) tick();
            v = (base == '0) ? DW'($urandom) : DW'(base * (i + 1));
            do_push((base == '0) ? int'($urandom_range(0, P - 1)) : i % P, v);
            exp_q.push_back(v);
            chk("collect_count", 32'(count), 32'(i + 1));
            chk("collect_valid", 32'(tx_valid), (i == len - 1) ? 32'd1 : 32'd0);
        end
        tx_ready = 1'b0;
        for (int e = 0; e < extra; e++) begin
            do_push(int'($urandom_range(0, P - 1)), DW'($urandom));
            exp_ovf = 1'b1;
            chk("drop_count", 32'(count), 32'(len));
            chk("drop_ovf", 32'(overflow), 32'd1);
        end
    endtask

    task automatic drain(input int ready_pct);
        int cyc = 0;
        int beat = 0;
        bit hs;
        while (exp_q.size() > 0 && cyc < 400) begin
            tx_ready = ($urandom_range(0, 99) < ready_pct);
            chk("send_valid", 32'(tx_valid), 32'd1);
            chk("send_data", 32'(tx_data), 32'(beat_val(exp_q[0], beat)));
            chk("send_count", 32'(count), 32'(exp_q.size()));
            hs = tx_ready;
            tick();
            cyc++;
            if (hs) begin
`ifdef TX_BYTE_SPLIT_EN
                if (beat == 0) beat = 1;
                else begin
                    beat = 0;
                    void'(exp_q.pop_front());
                end
`else
                void'(exp_q.pop_front());
`endif
            end
        end
        tx_ready = 1'b0;
        chk("drain_budget", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_valid", 32'(tx_valid), 32'd0);
        chk("done_count", 32'(count), 32'd0);
        tick();
        chk("done_once", 32'(done), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'(exp_ovf));
    endtask

    task automatic clear_fifo();
        rst_fifo = 1'b1;
        tick();
        rst_fifo = 1'b0;
        exp_ovf = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b1; rst_fifo = 1'b0; push_result = 1'b0; tx_ready = 1'b0;
        processor_number = '0; proc_result = '0; N = 4'd4;
        tick();
        tick();
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        reset = 1'b0;
        tick();

        // N=4 directed batch, back-to-back drain
        collect(4, 16'h0011, 0);
        drain(100);

        // backpressure on first result
        collect(2, '0, 0);
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(tx_valid), 32'd1);
            chk("bp_data", 32'(tx_data), 32'(beat_val(exp_q[0], 0)));
            chk("bp_count", 32'(count), 32'd2);
            tick();
        end
        drain(100);

        // pointer wrap across batches
        collect(3, '0, 0);
        drain(70);
        collect(8, '0, 0);
        drain(60);
        collect(8, '0, 0);
        drain(100);
        chk("wrap_ovf", 32'(overflow), 32'd0);

        // overflow: third push lands in SEND; flag stays set over the next batch
        collect(2, '0, 1);
        drain(80);
        collect(3, '0, 0);
        drain(50);
        clear_fifo();
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // N=0 pushes are dropped
        N = 4'd0;
        do_push(1, DW'($urandom));
        chk("n0_count", 32'(count), 32'd0);
        chk("n0_valid", 32'(tx_valid), 32'd0);
        chk("n0_ovf", 32'(overflow), 32'd1);
        clear_fifo();

        // length clamps to depth; single-entry batch
        collect(9, '0, 0);
        drain(60);
        collect(1, '0, 0);
        drain(100);

        // rst_fifo after 2 of 4 pushes, coinciding with a third push
        N = 4'd4;
        do_push(0, DW'($urandom));
        do_push(2, DW'($urandom));
        chk("mid_count", 32'(count), 32'd2);
        rst_fifo = 1'b1;
        do_push(3, DW'($urandom));
        rst_fifo = 1'b0;
        exp_q.delete();
        chk("rstf_count", 32'(count), 32'd0);
        chk("rstf_valid", 32'(tx_valid), 32'd0);
        collect(4, '0, 0);
        drain(90);

        // async reset during SEND
        collect(3, '0, 0);
        tx_ready = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        chk("areset_valid", 32'(tx_valid), 32'd0);
        chk("areset_count", 32'(count), 32'd0);
        chk("areset_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        tick();
        chk("post_reset_valid", 32'(tx_valid), 32'd0);
        collect(2, '0, 0);
        drain(100);

`ifdef TX_BYTE_SPLIT_EN
        collect(1, 16'hABCD, 0);
        drain(100);
`endif

        for (int r = 0; r < 6; r++) begin
            collect(int'($urandom_range(1, 15)), '0, int'($urandom_range(0, 1)));
            drain(int'($urandom_range(30, 100)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
